// File: rtl/sipo_pack_if.sv
// Stream bundle for sipo_pack: word input side and packed-block output side.
// The packer uses the slave modport, the producer/consumer pair uses master.
interface sipo_pack_if #(
  parameter int IN_W      = 8,
  parameter int NUM_WORDS = 16
);
  localparam int OUT_W = IN_W * NUM_WORDS;
  localparam int CNT_W = $clog2(NUM_WORDS + 1);

  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic [CNT_W-1:0] out_words;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_words
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_words
  );
endinterface

// File: rtl/sipo_pack.sv
// Serial-in/parallel-out packer: gathers NUM_WORDS words (or a short in_last block) into one block,
// then hands it to a separate output holding register so the collector can refill under back-pressure.
module sipo_pack #(
  parameter int IN_W      = 8,
  parameter int NUM_WORDS = 16,
  parameter int OUT_W     = IN_W * NUM_WORDS,
  parameter bit LSB_FIRST = 1'b1,
  parameter int CNT_W     = $clog2(NUM_WORDS + 1)
) (
  input logic        clk,
  input logic        reset,
  input logic        clear,
  sipo_pack_if.slave bus
);

  logic [OUT_W-1:0] coll;
  logic [OUT_W-1:0] out_data_q;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] out_words_q;
  logic             done;
  logic             out_valid_q;
  logic             accept;
  logic             xfer;
  logic             ends_block;

  // Bit offset of slot k inside the block, according to word placement order.
  function automatic int slot_lo(input int k);
    return LSB_FIRST ? (k * IN_W) : (OUT_W - (k + 1) * IN_W);
  endfunction

  assign accept     = bus.in_valid && !done;
  assign xfer       = done && (!out_valid_q || bus.out_ready);
  assign ends_block = bus.in_last || (cnt == CNT_W'(NUM_WORDS - 1));

  assign bus.in_ready  = !done;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_words = out_words_q;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      coll        <= '0;
      cnt         <= '0;
      done        <= 1'b0;
      out_data_q  <= '0;
      out_words_q <= '0;
      out_valid_q <= 1'b0;
    end else if (xfer) begin
      // cnt already counts the final word, so it is the block's word count.
      out_data_q  <= coll;
      out_words_q <= cnt;
      out_valid_q <= 1'b1;
      coll        <= '0;
      cnt         <= '0;
      done        <= 1'b0;
    end else begin
      if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (accept) begin
        for (int k = 0; k < NUM_WORDS; k++) begin
          if (cnt == CNT_W'(k)) begin
            coll[slot_lo(k) +: IN_W] <= bus.in_data;
          end
        end
        cnt <= cnt + CNT_W'(1);
        if (ends_block) begin
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sipo_pack.sv
// Directed bench for sipo_pack: 8x16 LSB-first (main), 8x16 MSB-first, and 32x4 LSB-first instances.
module tb_sipo_pack;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic clear = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  sipo_pack_if #(.IN_W(8),  .NUM_WORDS(16)) ia ();
  sipo_pack_if #(.IN_W(8),  .NUM_WORDS(16)) ib ();
  sipo_pack_if #(.IN_W(32), .NUM_WORDS(4))  ic ();

  sipo_pack #(.IN_W(8),  .NUM_WORDS(16), .LSB_FIRST(1'b1)) dut_a (.clk(clk), .reset(reset), .clear(clear), .bus(ia));
  sipo_pack #(.IN_W(8),  .NUM_WORDS(16), .LSB_FIRST(1'b0)) dut_b (.clk(clk), .reset(reset), .clear(clear), .bus(ib));
  sipo_pack #(.IN_W(32), .NUM_WORDS(4),  .LSB_FIRST(1'b1)) dut_c (.clk(clk), .reset(reset), .clear(clear), .bus(ic));

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Inputs change on the falling edge; the next rising edge samples them.
  task automatic send_a(input logic [7:0] d, input logic last);
    int n;
    ia.in_valid = 1'b1; ia.in_data = d; ia.in_last = last;
    n = 0;
    while (ia.in_ready !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    checks++;
    if (n >= 40) begin errors++; $display("FAIL send_timeout: in_ready=%b required 1", ia.in_ready); end
    @(negedge clk);
    ia.in_valid = 1'b0; ia.in_last = 1'b0;
  endtask

  task automatic wait_valid_a();
    int n;
    n = 0;
    while (ia.out_valid !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    checks++;
    if (n >= 40) begin errors++; $display("FAIL wait_out_valid: out_valid=%b required 1", ia.out_valid); end
  endtask

  task automatic test_reset();
    reset = 1'b1; ia.in_valid = 1'b1; ia.in_data = 8'h55;
    @(negedge clk); @(negedge clk);
    reset = 1'b0; ia.in_valid = 1'b0;
    checks++; if (ia.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b required 0", ia.out_valid); end
    checks++; if (ia.out_words !== 5'd0) begin errors++; $display("FAIL reset_out_words: got %0d required 0", ia.out_words); end
    checks++; if (ia.out_data !== 128'h0) begin errors++; $display("FAIL reset_out_data: got %h required 0", ia.out_data); end
    checks++; if (ia.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b required 1", ia.in_ready); end
  endtask

  task automatic test_full_block();
    ia.out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      checks++; if (ia.in_ready !== 1'b1) begin errors++; $display("FAIL full_in_ready_%0d: got %b required 1", i, ia.in_ready); end
      ia.in_valid = 1'b1; ia.in_data = 8'(i); ia.in_last = 1'b0;
      @(negedge clk);
    end
    ia.in_valid = 1'b0;
    checks++; if (ia.in_ready !== 1'b0) begin errors++; $display("FAIL full_done_in_ready: got %b required 0", ia.in_ready); end
    checks++; if (ia.out_valid !== 1'b0) begin errors++; $display("FAIL full_early_valid: got %b required 0", ia.out_valid); end
    @(negedge clk);
    checks++; if (ia.out_valid !== 1'b1) begin errors++; $display("FAIL full_out_valid: got %b required 1", ia.out_valid); end
    checks++; if (ia.out_data !== 128'h0F0E0D0C0B0A09080706050403020100) begin errors++; $display("FAIL full_out_data: got %h required 0f0e..0100", ia.out_data); end
    checks++; if (ia.out_words !== 5'd16) begin errors++; $display("FAIL full_out_words: got %0d required 16", ia.out_words); end
    checks++; if (ia.in_ready !== 1'b1) begin errors++; $display("FAIL full_in_ready_back: got %b required 1", ia.in_ready); end
    @(negedge clk);
    checks++; if (ia.out_valid !== 1'b0) begin errors++; $display("FAIL full_consumed: got %b required 0", ia.out_valid); end
    checks++; if (ia.out_data !== 128'h0F0E0D0C0B0A09080706050403020100) begin errors++; $display("FAIL full_data_kept: got %h", ia.out_data); end
  endtask

  task automatic test_short_block();
    ia.out_ready = 1'b1;
    send_a(8'hAA, 1'b0); send_a(8'hBB, 1'b0); send_a(8'hCC, 1'b1);
    checks++; if (ia.in_ready !== 1'b0) begin errors++; $display("FAIL short_done: in_ready got %b required 0", ia.in_ready); end
    @(negedge clk);
    checks++; if (ia.out_valid !== 1'b1) begin errors++; $display("FAIL short_out_valid: got %b required 1", ia.out_valid); end
    checks++; if (ia.out_data !== 128'h00CCBBAA) begin errors++; $display("FAIL short_out_data: got %h required 00ccbbaa", ia.out_data); end
    checks++; if (ia.out_words !== 5'd3) begin errors++; $display("FAIL short_out_words: got %0d required 3", ia.out_words); end
    send_a(8'h11, 1'b1);
    wait_valid_a();
    checks++; if (ia.out_data !== 128'h11) begin errors++; $display("FAIL short_next_slot0: got %h required 11", ia.out_data); end
    checks++; if (ia.out_words !== 5'd1) begin errors++; $display("FAIL short_next_words: got %0d required 1", ia.out_words); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    ia.out_ready = 1'b0;
    for (int i = 0; i < 16; i++) send_a(8'h10 + 8'(i), 1'b0);
    for (int i = 0; i < 16; i++) send_a(8'h20 + 8'(i), 1'b0);
    checks++; if (ia.out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid: got %b required 1", ia.out_valid); end
    checks++; if (ia.out_data !== 128'h1F1E1D1C1B1A19181716151413121110) begin errors++; $display("FAIL bp_block1: got %h", ia.out_data); end
    checks++; if (ia.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_low: got %b required 0", ia.in_ready); end
    ia.in_valid = 1'b1; ia.in_data = 8'hEE;
    @(negedge clk); @(negedge clk);
    checks++; if (ia.out_data !== 128'h1F1E1D1C1B1A19181716151413121110) begin errors++; $display("FAIL bp_block1_hold: got %h", ia.out_data); end
    checks++; if (ia.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_hold: got %b required 0", ia.in_ready); end
    ia.in_valid = 1'b0; ia.out_ready = 1'b1;
    @(negedge clk);
    ia.out_ready = 1'b0;
    checks++; if (ia.out_valid !== 1'b1) begin errors++; $display("FAIL bp_no_bubble: got %b required 1", ia.out_valid); end
    checks++; if (ia.out_data !== 128'h2F2E2D2C2B2A29282726252423222120) begin errors++; $display("FAIL bp_block2: got %h", ia.out_data); end
    checks++; if (ia.in_ready !== 1'b1) begin errors++; $display("FAIL bp_in_ready_back: got %b required 1", ia.in_ready); end
    @(negedge clk);
    checks++; if (ia.out_valid !== 1'b1) begin errors++; $display("FAIL bp_block2_hold: got %b required 1", ia.out_valid); end
    ia.out_ready = 1'b1;
    @(negedge clk);
    checks++; if (ia.out_valid !== 1'b0) begin errors++; $display("FAIL bp_drained: got %b required 0", ia.out_valid); end
    send_a(8'h33, 1'b1);
    wait_valid_a();
    checks++; if (ia.out_data !== 128'h33) begin errors++; $display("FAIL bp_after_data: got %h required 33", ia.out_data); end
    checks++; if (ia.out_words !== 5'd1) begin errors++; $display("FAIL bp_after_words: got %0d required 1", ia.out_words); end
    @(negedge clk);
  endtask

  task automatic test_clear();
    ia.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) send_a(8'h50 + 8'(i), 1'b0);
    clear = 1'b1; ia.in_valid = 1'b1; ia.in_data = 8'h99;
    @(negedge clk);
    clear = 1'b0; ia.in_valid = 1'b0;
    checks++; if (ia.out_valid !== 1'b0) begin errors++; $display("FAIL clr_mid_valid: got %b required 0", ia.out_valid); end
    checks++; if (ia.out_words !== 5'd0) begin errors++; $display("FAIL clr_mid_words: got %0d required 0", ia.out_words); end
    checks++; if (ia.in_ready !== 1'b1) begin errors++; $display("FAIL clr_mid_in_ready: got %b required 1", ia.in_ready); end
    send_a(8'hA1, 1'b0); send_a(8'hA2, 1'b1);
    wait_valid_a();
    checks++; if (ia.out_data !== 128'hA2A1) begin errors++; $display("FAIL clr_mid_stale: got %h required a2a1", ia.out_data); end
    checks++; if (ia.out_words !== 5'd2) begin errors++; $display("FAIL clr_mid_short_words: got %0d required 2", ia.out_words); end
    @(negedge clk);
    ia.out_ready = 1'b0;
    for (int i = 0; i < 16; i++) send_a(8'h60 + 8'(i), 1'b0);
    wait_valid_a();
    checks++; if (ia.out_data !== 128'h6F6E6D6C6B6A69686766656463626160) begin errors++; $display("FAIL clr_pend_block: got %h", ia.out_data); end
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    checks++; if (ia.out_valid !== 1'b0) begin errors++; $display("FAIL clr_pend_valid: got %b required 0", ia.out_valid); end
    checks++; if (ia.out_words !== 5'd0) begin errors++; $display("FAIL clr_pend_words: got %0d required 0", ia.out_words); end
    checks++; if (ia.out_data !== 128'h0) begin errors++; $display("FAIL clr_pend_data: got %h required 0", ia.out_data); end
    ia.out_ready = 1'b1;
    for (int i = 0; i < 16; i++) send_a(8'h70 + 8'(i), 1'b0);
    wait_valid_a();
    checks++; if (ia.out_data !== 128'h7F7E7D7C7B7A79787776757473727170) begin errors++; $display("FAIL clr_refill: got %h", ia.out_data); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    ia.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) send_a(8'h80 + 8'(i), 1'b0);
    reset = 1'b1; ia.in_valid = 1'b1; ia.in_data = 8'h77;
    @(negedge clk);
    reset = 1'b0; ia.in_valid = 1'b0;
    checks++; if (ia.out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %b required 0", ia.out_valid); end
    checks++; if (ia.out_words !== 5'd0) begin errors++; $display("FAIL rst_mid_words: got %0d required 0", ia.out_words); end
    checks++; if (ia.out_data !== 128'h0) begin errors++; $display("FAIL rst_mid_data: got %h required 0", ia.out_data); end
    checks++; if (ia.in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_in_ready: got %b required 1", ia.in_ready); end
    send_a(8'h01, 1'b1);
    wait_valid_a();
    checks++; if (ia.out_data !== 128'h01) begin errors++; $display("FAIL rst_mid_discard: got %h required 01", ia.out_data); end
    @(negedge clk);
  endtask

  task automatic test_msb_first();
    for (int i = 0; i < 16; i++) begin
      ib.in_valid = 1'b1; ib.in_data = 8'(i);
      @(negedge clk);
    end
    ib.in_valid = 1'b0;
    checks++; if (ib.in_ready !== 1'b0) begin errors++; $display("FAIL msb_done: in_ready got %b required 0", ib.in_ready); end
    @(negedge clk);
    checks++; if (ib.out_valid !== 1'b1) begin errors++; $display("FAIL msb_out_valid: got %b required 1", ib.out_valid); end
    checks++; if (ib.out_data !== 128'h000102030405060708090A0B0C0D0E0F) begin errors++; $display("FAIL msb_out_data: got %h required 0001..0e0f", ib.out_data); end
    checks++; if (ib.out_words !== 5'd16) begin errors++; $display("FAIL msb_out_words: got %0d required 16", ib.out_words); end
    @(negedge clk);
  endtask

  task automatic test_wide();
    for (int i = 0; i < 4; i++) begin
      checks++; if (ic.in_ready !== 1'b1) begin errors++; $display("FAIL wide_in_ready_%0d: got %b required 1", i, ic.in_ready); end
      ic.in_valid = 1'b1; ic.in_data = 32'hA0000000 + 32'(i);
      @(negedge clk);
    end
    ic.in_valid = 1'b0;
    checks++; if (ic.in_ready !== 1'b0) begin errors++; $display("FAIL wide_done: in_ready got %b required 0", ic.in_ready); end
    @(negedge clk);
    checks++; if (ic.out_valid !== 1'b1) begin errors++; $display("FAIL wide_out_valid: got %b required 1", ic.out_valid); end
    checks++; if (ic.out_data !== 128'hA0000003_A0000002_A0000001_A0000000) begin errors++; $display("FAIL wide_out_data: got %h", ic.out_data); end
    checks++; if (ic.out_words !== 3'd4) begin errors++; $display("FAIL wide_out_words: got %0d required 4", ic.out_words); end
    checks++; if (ic.in_ready !== 1'b1) begin errors++; $display("FAIL wide_in_ready_back: got %b required 1", ic.in_ready); end
    @(negedge clk);
  endtask

  initial begin
    ia.in_valid = 1'b0; ia.in_data = '0; ia.in_last = 1'b0; ia.out_ready = 1'b1;
    ib.in_valid = 1'b0; ib.in_data = '0; ib.in_last = 1'b0; ib.out_ready = 1'b1;
    ic.in_valid = 1'b0; ic.in_data = '0; ic.in_last = 1'b0; ic.out_ready = 1'b1;
    test_reset();
    test_full_block();
    test_short_block();
    test_back_to_back();
    test_clear();
    test_reset_mid();
    test_msb_first();
    test_wide();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
